// File: rtl/ibex_csr_bank.sv
// ibex_csr_bank
// -------------
// A bank of NumRegs control/status registers, each Width bits wide. There is
// one shared write port and one combinational read port.
//
// Write ops: WRITE replaces the register value, SET ORs the operand in, and
// CLEAR ANDs out the operand bits. Every op is filtered by WritableMask.
// Each register has a write-once lock that only reset clears. An optional
// inverted shadow copy gives integrity checking, and a fault-injection input
// flips shadow bit 0 of the addressed register.
//
// Ports:
//   clk_i        : clock; all state updates on the rising edge
//   rst_i        : synchronous, active-high reset
//   wr_addr_i    : target register of write / lock / inject
//   wr_op_i      : 00 NONE, 01 WRITE, 10 SET, 11 CLEAR
//   wr_data_i    : write operand
//   lock_i       : set the lock bit of wr_addr_i
//   err_inject_i : toggle shadow bit 0 of wr_addr_i
//   rd_addr_i    : read select
//   rd_data_o    : value of the selected register (0 if out of range)
//   rd_error_o   : shadow mismatch on the selected register
//   locked_o     : per-register lock bits (registered)
//   wr_denied_o  : one-cycle pulse; the previous cycle's write was rejected
//   err_sticky_o : an integrity error has been seen since reset
//
// There is no valid/ready handshake. An op is a single-cycle request. It is
// accepted or denied at the clock edge where it is presented, and
// wr_denied_o reports the outcome one cycle later.
module ibex_csr_bank #(
    parameter int unsigned      Width        = 32,
    parameter int unsigned      NumRegs      = 4,
    parameter bit               ShadowCopy   = 1'b1,
    parameter logic [Width-1:0] ResetValue   = '0,
    parameter logic [Width-1:0] WritableMask = '1,
    localparam int unsigned     AddrW        = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [AddrW-1:0]   wr_addr_i,
    input  logic [1:0]         wr_op_i,
    input  logic [Width-1:0]   wr_data_i,
    input  logic               lock_i,
    input  logic               err_inject_i,
    input  logic [AddrW-1:0]   rd_addr_i,
    output logic [Width-1:0]   rd_data_o,
    output logic               rd_error_o,
    output logic [NumRegs-1:0] locked_o,
    output logic               wr_denied_o,
    output logic               err_sticky_o
);

    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    logic [Width-1:0]   q_regs   [NumRegs];
    logic [Width-1:0]   comp_val [NumRegs];
    logic [Width-1:0]   new_val  [NumRegs];
    logic [NumRegs-1:0] addr_hit;
    logic [NumRegs-1:0] wr_en;
    logic [NumRegs-1:0] locked_q;
    logic               wr_denied_q;
    logic               wr_denied_d;

    // Per-register decode. The loop only covers existing registers, so an
    // out-of-range wr_addr_i never produces a hit. That single fact makes
    // out-of-range writes, locks and injects all fall through harmlessly.
    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            addr_hit[i] = (wr_addr_i == AddrW'(i));
            // The lock is sampled before the edge, so a lock and a write
            // arriving in the same cycle still let that write through.
            wr_en[i]    = addr_hit[i] && (wr_op_i != OpNone) && !locked_q[i];
            case (wr_op_i)
                OpSet:   comp_val[i] = q_regs[i] | wr_data_i;
                OpClear: comp_val[i] = q_regs[i] & ~wr_data_i;
                default: comp_val[i] = wr_data_i;
            endcase
            // Bits that are not writable keep their current value. That
            // value is always ResetValue, since no write can change them.
            new_val[i] = (comp_val[i] & WritableMask) | (q_regs[i] & ~WritableMask);
        end
    end

    // Any real op that did not land on an unlocked, in-range register is denied.
    assign wr_denied_d = (wr_op_i != OpNone) && (wr_en == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                q_regs[i] <= ResetValue;
            end
            locked_q    <= '0;
            wr_denied_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                if (wr_en[i]) begin
                    q_regs[i] <= new_val[i];
                end
            end
            locked_q    <= locked_q | (addr_hit & {NumRegs{lock_i}});
            wr_denied_q <= wr_denied_d;
        end
    end

    // Read port: pure mux on registered state, with no write bypass.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (rd_addr_i == AddrW'(i)) begin
                rd_data_o = q_regs[i];
            end
        end
    end

    assign locked_o    = locked_q;
    assign wr_denied_o = wr_denied_q;

    if (ShadowCopy) begin : g_shadow
        logic [Width-1:0]   shadow_q [NumRegs];
        logic [Width-1:0]   shadow_d [NumRegs];
        logic [NumRegs-1:0] mismatch;
        logic [NumRegs-1:0] rd_hit;
        logic               err_sticky_q;

        always_comb begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                shadow_d[i] = wr_en[i] ? ~new_val[i] : shadow_q[i];
                // The inject applies after the write load, so a write and an
                // inject in the same cycle still leave a corrupted shadow.
                if (err_inject_i && addr_hit[i]) begin
                    shadow_d[i][0] = ~shadow_d[i][0];
                end
                mismatch[i] = (q_regs[i] != ~shadow_q[i]);
                rd_hit[i]   = (rd_addr_i == AddrW'(i));
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned i = 0; i < NumRegs; i++) begin
                    shadow_q[i] <= ~ResetValue;
                end
                err_sticky_q <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < NumRegs; i++) begin
                    shadow_q[i] <= shadow_d[i];
                end
                // This watches every register, not only the one being read.
                err_sticky_q <= err_sticky_q | (|mismatch);
            end
        end

        assign rd_error_o   = |(mismatch & rd_hit);
        assign err_sticky_o = err_sticky_q;
    end else begin : g_no_shadow
        logic unused_inject;
        assign unused_inject = err_inject_i;
        assign rd_error_o    = 1'b0;
        assign err_sticky_o  = 1'b0;
    end

endmodule

// File: tb/tb_ibex_csr_bank.sv
// Directed testbench for ibex_csr_bank. Three instances share one stimulus
// stream:
//   dut_a : 4 regs, ResetValue 0xA5, all bits writable
//   dut_m : 4 regs, ResetValue 0xA5, WritableMask 0x0000_FFFF
//   dut_n : 3 regs, ResetValue 0xA5 (address 3 is out of range)
module tb_ibex_csr_bank;

    localparam logic [31:0] Rv = 32'h0000_00A5;

    logic        clk;
    logic        rst;
    logic [1:0]  wr_addr;
    logic [1:0]  wr_op;
    logic [31:0] wr_data;
    logic        lock;
    logic        inject;
    logic [1:0]  rd_addr;

    logic [31:0] a_rd_data, m_rd_data, n_rd_data;
    logic        a_rd_err,  m_rd_err,  n_rd_err;
    logic [3:0]  a_locked,  m_locked;
    logic [2:0]  n_locked;
    logic        a_denied,  m_denied,  n_denied;
    logic        a_sticky,  m_sticky,  n_sticky;

    int checks = 0;
    int errors = 0;

    ibex_csr_bank #(.Width(32), .NumRegs(4), .ShadowCopy(1'b1),
                    .ResetValue(Rv), .WritableMask(32'hFFFF_FFFF)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_addr_i(wr_addr), .wr_op_i(wr_op),
        .wr_data_i(wr_data), .lock_i(lock), .err_inject_i(inject),
        .rd_addr_i(rd_addr), .rd_data_o(a_rd_data), .rd_error_o(a_rd_err),
        .locked_o(a_locked), .wr_denied_o(a_denied), .err_sticky_o(a_sticky));

    ibex_csr_bank #(.Width(32), .NumRegs(4), .ShadowCopy(1'b1),
                    .ResetValue(Rv), .WritableMask(32'h0000_FFFF)) dut_m (
        .clk_i(clk), .rst_i(rst), .wr_addr_i(wr_addr), .wr_op_i(wr_op),
        .wr_data_i(wr_data), .lock_i(lock), .err_inject_i(inject),
        .rd_addr_i(rd_addr), .rd_data_o(m_rd_data), .rd_error_o(m_rd_err),
        .locked_o(m_locked), .wr_denied_o(m_denied), .err_sticky_o(m_sticky));

    ibex_csr_bank #(.Width(32), .NumRegs(3), .ShadowCopy(1'b1),
                    .ResetValue(Rv), .WritableMask(32'hFFFF_FFFF)) dut_n (
        .clk_i(clk), .rst_i(rst), .wr_addr_i(wr_addr), .wr_op_i(wr_op),
        .wr_data_i(wr_data), .lock_i(lock), .err_inject_i(inject),
        .rd_addr_i(rd_addr), .rd_data_o(n_rd_data), .rd_error_o(n_rd_err),
        .locked_o(n_locked), .wr_denied_o(n_denied), .err_sticky_o(n_sticky));

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_op  = 2'b00;
        lock   = 1'b0;
        inject = 1'b0;
    endtask

    task automatic op(input logic [1:0] a, input logic [1:0] o, input logic [31:0] d,
                      input logic lk, input logic inj);
        wr_addr = a;
        wr_op   = o;
        wr_data = d;
        lock    = lk;
        inject  = inj;
        tick();
        idle();
    endtask

    task automatic rd(input logic [1:0] a);
        rd_addr = a;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        for (int r = 0; r < 4; r++) begin
            rd(2'(r));
            chk($sformatf("a_reset_data_r%0d", r), a_rd_data, Rv);
            chk($sformatf("a_reset_err_r%0d", r), a_rd_err, 1'b0);
        end
        chk("n_reset_data_oor", n_rd_data, 32'h0);
        chk("a_reset_locked", a_locked, 4'b0000);
        chk("a_reset_sticky", a_sticky, 1'b0);
        chk("a_reset_denied", a_denied, 1'b0);

        // WRITE / SET / CLEAR on reg 1, full mask and partial mask
        op(2'd1, 2'b01, 32'hF0F0_F0F0, 1'b0, 1'b0);
        rd(2'd1);
        chk("a_write", a_rd_data, 32'hF0F0_F0F0);
        chk("m_write", m_rd_data, 32'h0000_F0F0);
        wr_addr = 2'd1;
        wr_op   = 2'b10;
        wr_data = 32'h0000_000F;
        #1;
        chk("a_rd_during_wr_old", a_rd_data, 32'hF0F0_F0F0);
        tick();
        idle();
        rd(2'd1);
        chk("a_set", a_rd_data, 32'hF0F0_F0FF);
        chk("m_set", m_rd_data, 32'h0000_F0FF);
        op(2'd1, 2'b11, 32'hF000_0000, 1'b0, 1'b0);
        chk("a_clear", a_rd_data, 32'h00F0_F0FF);
        chk("m_clear", m_rd_data, 32'h0000_F0FF);
        chk("a_clear_denied", a_denied, 1'b0);

        // Lock plus write in the same cycle, then a denied write
        op(2'd2, 2'b01, 32'h0000_1234, 1'b1, 1'b0);
        rd(2'd2);
        chk("a_lock_write_data", a_rd_data, 32'h0000_1234);
        chk("a_locked_r2", a_locked, 4'b0100);
        chk("n_locked_r2", n_locked, 3'b100);
        chk("a_lock_write_denied", a_denied, 1'b0);
        op(2'd2, 2'b01, 32'h0000_5678, 1'b0, 1'b0);
        chk("a_locked_wr_data", a_rd_data, 32'h0000_1234);
        chk("a_locked_wr_denied", a_denied, 1'b1);
        tick();
        chk("a_denied_pulse_end", a_denied, 1'b0);
        op(2'd0, 2'b01, 32'h0000_BEEF, 1'b0, 1'b0);
        rd(2'd0);
        chk("a_r0_writable", a_rd_data, 32'h0000_BEEF);
        chk("a_r0_denied", a_denied, 1'b0);

        // Error injection on reg 3, observed through reg 0 and then reg 3
        op(2'd3, 2'b00, 32'h0, 1'b0, 1'b1);
        chk("a_inject_rd_err_r0", a_rd_err, 1'b0);
        chk("a_inject_sticky_early", a_sticky, 1'b0);
        tick();
        chk("a_inject_sticky", a_sticky, 1'b1);
        chk("n_inject_oor_sticky", n_sticky, 1'b0);
        rd(2'd3);
        chk("a_inject_rd_err_r3", a_rd_err, 1'b1);
        chk("n_oor_rd_err", n_rd_err, 1'b0);
        op(2'd3, 2'b01, 32'h0000_0055, 1'b0, 1'b0);
        chk("a_rewrite_rd_err", a_rd_err, 1'b0);
        chk("a_rewrite_data", a_rd_data, 32'h0000_0055);
        chk("a_sticky_holds", a_sticky, 1'b1);
        chk("n_oor_write_denied", n_denied, 1'b1);
        chk("n_oor_rd_data", n_rd_data, 32'h0);
        chk("a_oor_ok_denied", a_denied, 1'b0);

        // Lock with op NONE; out-of-range lock is ignored on the 3-reg bank
        op(2'd3, 2'b00, 32'h0, 1'b1, 1'b0);
        chk("a_locked_r3", a_locked, 4'b1100);
        chk("n_locked_oor", n_locked, 3'b100);
        chk("a_none_no_deny", a_denied, 1'b0);

        // Write and inject in the same cycle on reg 1
        op(2'd1, 2'b01, 32'h0000_CAFE, 1'b0, 1'b1);
        rd(2'd1);
        chk("a_wr_inj_data", a_rd_data, 32'h0000_CAFE);
        chk("a_wr_inj_err", a_rd_err, 1'b1);

        // Reset overrides a same-cycle write plus inject
        rst     = 1'b1;
        wr_addr = 2'd0;
        wr_op   = 2'b01;
        wr_data = 32'h0000_DEAD;
        inject  = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rd(2'd0);
        chk("a_rst_data", a_rd_data, Rv);
        chk("a_rst_err", a_rd_err, 1'b0);
        chk("a_rst_denied", a_denied, 1'b0);
        chk("a_rst_sticky", a_sticky, 1'b0);
        chk("a_rst_locked", a_locked, 4'b0000);
        tick();
        chk("a_rst_sticky_after", a_sticky, 1'b0);
        chk("a_rst_denied_after", a_denied, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
